// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported synchronous SRAM between the
// instruction-fetch (IM) and data-access (DM) requesters. It serves one request
// at a time and holds the memory controls for WAIT_CYCLES+1 cycles. In the
// following cycle it captures read data and pulses the owner's ack for one
// cycle.
//
// Build option:
//   MEM_ARB_RR_EN  When defined, ties are broken round-robin: the requester
//                  not granted last wins. When undefined, DM always wins a tie.
//
// Ports:
//   clock, reset         system clock; synchronous active-high reset
//   im_req/im_addr       fetch request (held until im_ack)
//   im_rdata/im_ack      fetch data (held between acks) / completion pulse
//   dm_req/dm_write      data request; 1 = store
//   dm_addr/dm_wdata     data address / store data
//   dm_rdata/dm_ack      load data (updated on load acks only) / completion pulse
//   busy                 high whenever the sequencer is not idle
//   mem_enable/read/write, mem_address, mem_in, mem_out   SRAM side
module mem_arbiter #(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              im_req,
  input  logic [ADDR_W-1:0] im_addr,
  output logic [DATA_W-1:0] im_rdata,
  output logic              im_ack,
  input  logic              dm_req,
  input  logic              dm_write,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ack,
  output logic              busy,
  output logic              mem_enable,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_in,
  input  logic [DATA_W-1:0] mem_out
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic              own_dm;   // 1 = current access belongs to DM
  logic              wr;       // latched store flag (always 0 for IM)
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              pick_dm;  // arbitration result for this cycle

`ifdef MEM_ARB_RR_EN
  logic last_dm;  // last grant went to DM; reset value makes IM win the first tie

  assign pick_dm = dm_req && (!im_req || !last_dm);

  always_ff @(posedge clock) begin
    if (reset)
      last_dm <= 1'b1;
    else if (state == IDLE && (im_req || dm_req))
      last_dm <= pick_dm;
  end
`else
  assign pick_dm = dm_req;
`endif

  // Latched values stay stable through every ACCESS cycle.
  assign mem_address = addr_q;
  assign mem_in      = wdata_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      own_dm     <= 1'b0;
      wr         <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      busy       <= 1'b0;
      mem_enable <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      im_ack     <= 1'b0;
      dm_ack     <= 1'b0;
      im_rdata   <= '0;
      dm_rdata   <= '0;
    end else begin
      im_ack <= 1'b0;
      dm_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (im_req || dm_req) begin
            own_dm     <= pick_dm;
            wr         <= pick_dm && dm_write;
            addr_q     <= pick_dm ? dm_addr : im_addr;
            wdata_q    <= pick_dm ? dm_wdata : '0;
            cnt        <= 4'(WAIT_CYCLES);
            busy       <= 1'b1;
            mem_enable <= 1'b1;
            mem_read   <= !(pick_dm && dm_write);
            mem_write  <= pick_dm && dm_write;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            // mem_out is valid at the end of the last ACCESS cycle.
            mem_enable <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            if (!wr) begin
              if (own_dm) dm_rdata <= mem_out;
              else        im_rdata <= mem_out;
            end
            if (own_dm) dm_ack <= 1'b1;
            else        im_ack <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter. A transaction-level model tracks the grant edge of the
// current access. From that edge alone it derives which cycles are ACCESS and
// which cycle is DONE, and a shadow memory gives the expected read data. The
// model is compared with the DUT every cycle. Directed scenarios with literal
// expectations come first, followed by a random phase.
module tb_mem_arbiter;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int W  = 1;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic im_req = 1'b0, dm_req = 1'b0, dm_write = 1'b0;
  logic [AW-1:0] im_addr = '0, dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0;
  logic [DW-1:0] im_rdata, dm_rdata, mem_in, mem_out;
  logic im_ack, dm_ack, busy, mem_enable, mem_read, mem_write;
  logic [AW-1:0] mem_address;

  int vectors = 0;
  int errors  = 0;

  always #5 clock = ~clock;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W)) dut (
    .clock(clock), .reset(reset),
    .im_req(im_req), .im_addr(im_addr), .im_rdata(im_rdata), .im_ack(im_ack),
    .dm_req(dm_req), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack), .busy(busy),
    .mem_enable(mem_enable), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_in(mem_in), .mem_out(mem_out)
  );

  // Bench SRAM: combinational read, write on the clock edge.
  logic [DW-1:0] sram [0:4095];
  assign mem_out = sram[mem_address];
  always @(posedge clock) if (mem_enable && mem_write) sram[mem_address] <= mem_in;

  // ---------------- reference model ----------------
  int e = 0;             // index of the most recent rising edge
  int g = 0;             // edge at which the current access was granted
  bit act = 0;           // g refers to a valid grant
  bit o_dm = 0, o_wr = 0, last_dm = 1;
  logic [AW-1:0] o_addr = '0;
  logic [DW-1:0] o_wdata = '0, x_im = '0, x_dm = '0;
  logic [DW-1:0] shadow [0:4095];

  task automatic model_step();
    bit tie_dm;
    e++;
    if (reset) begin
      act = 0; x_im = '0; x_dm = '0; last_dm = 1;
    end else begin
      if (act && e == g + W + 1) begin
        if (o_wr)      shadow[o_addr] = o_wdata;
        else if (o_dm) x_dm = shadow[o_addr];
        else           x_im = shadow[o_addr];
      end
      // A new grant is possible once W+3 edges have passed since the last one.
      if (!act || e >= g + W + 3) begin
        act = 0;
        if (im_req || dm_req) begin
`ifdef MEM_ARB_RR_EN
          tie_dm = !last_dm;
`else
          tie_dm = 1'b1;
`endif
          o_dm    = dm_req && (!im_req || tie_dm);
          last_dm = o_dm;
          o_wr    = o_dm && dm_write;
          o_addr  = o_dm ? dm_addr : im_addr;
          o_wdata = dm_wdata;
          g = e; act = 1;
        end
      end
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] x);
    vectors++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0h want %0h", nm, e, a, x);
    end
  endtask

  task automatic compare();
    bit acc, dn;
    acc = act && e >= g && e <= g + W;
    dn  = act && e == g + W + 1;
    chk("busy", busy, acc || dn);
    chk("mem_enable", mem_enable, acc);
    chk("mem_read", mem_read, acc && !o_wr);
    chk("mem_write", mem_write, acc && o_wr);
    chk("im_ack", im_ack, dn && !o_dm);
    chk("dm_ack", dm_ack, dn && o_dm);
    chk("im_rdata", im_rdata, x_im);
    chk("dm_rdata", dm_rdata, x_dm);
    if (acc) begin
      chk("mem_address", mem_address, o_addr);
      if (o_wr) chk("mem_in", mem_in, o_wdata);
    end
  endtask

  initial forever begin @(posedge clock); model_step(); end
  initial forever begin @(negedge clock); compare(); end

  task automatic wait_ack(output bit was_dm, output int at);
    was_dm = 0; at = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (im_ack || dm_ack) begin was_dm = dm_ack; at = e; return; end
    end
    vectors++; errors++;
    $display("FAIL ack_timeout at edge %0d: got no ack want ack within 40 cycles", e);
  endtask

  // ---------------- stimulus ----------------
  bit own [4];
  int at  [4];
  bit ob, ia, da, gen;
  int t;
  bit exp_own [4];

  initial begin
    for (int i = 0; i < 4096; i++) begin
      sram[i]   = 32'hA500_0000 + i * 13;
      shadow[i] = 32'hA500_0000 + i * 13;
    end
    sram[4] = 32'hDEADBEEF; shadow[4] = 32'hDEADBEEF;

    // reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_busy", busy, 0);
    chk("rst_mem_address", mem_address, 0);
    chk("rst_mem_in", mem_in, 0);
    chk("rst_rdata", {im_rdata, dm_rdata}, 0);
    @(posedge clock); #1 reset = 0;

    // single fetch from 0x004
    @(posedge clock); #1 im_req = 1; im_addr = 12'h004;
    @(negedge clock); chk("fetch_idle_busy", busy, 0);
    repeat (W + 1) begin @(negedge clock); chk("fetch_mem_read", mem_read, 1); chk("fetch_noack", im_ack, 0); end
    @(negedge clock);
    chk("fetch_ack", im_ack, 1);
    chk("fetch_data", im_rdata, 32'hDEADBEEF);
    chk("fetch_read_off", mem_read, 0);
    @(posedge clock); #1 im_req = 0;

    // store 0x12345678 to 0x010, then a load from the same address
    @(posedge clock); #1 dm_req = 1; dm_write = 1; dm_addr = 12'h010; dm_wdata = 32'h12345678;
    @(negedge clock);
    repeat (W + 1) begin @(negedge clock); chk("store_mem_write", mem_write, 1); end
    @(negedge clock);
    chk("store_ack", dm_ack, 1);
    chk("store_rdata_held", dm_rdata, 0);
    @(posedge clock); #1 dm_write = 0;   // request held: new load
    @(negedge clock); chk("load_idle_busy", busy, 0);
    repeat (W + 1) @(negedge clock);
    @(negedge clock);
    chk("load_ack", dm_ack, 1);
    chk("load_data", dm_rdata, 32'h12345678);
    @(posedge clock); #1 dm_req = 0;

    // reset during the second ACCESS cycle
    @(posedge clock); #1 im_req = 1; im_addr = 12'h008;
    @(posedge clock);
    @(posedge clock); #1 reset = 1;
    @(negedge clock); chk("abort_busy_pre", busy, 1);
    @(posedge clock); #1 reset = 0; im_req = 0;
    @(negedge clock);
    chk("abort_busy", busy, 0);
    chk("abort_ack", {im_ack, dm_ack}, 0);
    chk("abort_mem_ctl", {mem_enable, mem_read, mem_write}, 0);
    chk("abort_rdata", {im_rdata, dm_rdata}, 0);
    @(posedge clock); #1 im_req = 1; im_addr = 12'h004;
    wait_ack(ob, t);
    chk("refetch_owner", ob, 0);
    chk("refetch_data", im_rdata, 32'hDEADBEEF);
    @(posedge clock); #1 im_req = 0;

    // both requests held from reset release
    @(posedge clock); #1 reset = 1; im_req = 1; dm_req = 1; dm_write = 0;
    im_addr = 12'h004; dm_addr = 12'h010;
    @(posedge clock); #1 reset = 0;
`ifdef MEM_ARB_RR_EN
    exp_own = '{0, 1, 0, 1};
`else
    exp_own = '{1, 1, 1, 1};
`endif
    for (int k = 0; k < 4; k++) wait_ack(own[k], at[k]);
    for (int k = 0; k < 4; k++) chk($sformatf("tie_owner%0d", k), own[k], exp_own[k]);
    for (int k = 1; k < 4; k++) chk($sformatf("tie_gap%0d", k), at[k] - at[k-1], W + 3);
    @(posedge clock); #1 dm_req = 0;
    wait_ack(ob, t);
    chk("tie_tail_owner", ob, 0);
    chk("tie_tail_gap", t - at[3], W + 3);
    @(posedge clock); #1 im_req = 0;

    // random traffic, then drain with no new requests
    for (int c = 0; c < 1640; c++) begin
      gen = (c < 1600);
      @(negedge clock); ia = im_ack; da = dm_ack;
      @(posedge clock); #1;
      if (!im_req || ia) begin
        im_req  = gen && ($urandom_range(0, 2) != 0);
        im_addr = AW'($urandom_range(0, 31));
      end
      if (!dm_req || da) begin
        dm_req   = gen && ($urandom_range(0, 2) != 0);
        dm_write = 1'($urandom_range(0, 1));
        dm_addr  = AW'($urandom_range(0, 31));
        dm_wdata = $urandom;
      end
    end
    repeat (4) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
